// File: rtl/umtrx_rx_arb_pkg.sv
// Shared types and constants for the UmTRX RX packet arbiter.
package umtrx_rx_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PASS = 1'b1
  } arb_state_t;

  localparam int VITA_W     = 36;
  localparam int SOF_BIT    = 32;
  localparam int EOF_BIT    = 33;
  localparam int MAX_CHAINS = 4;

endpackage

// File: rtl/umtrx_rr_pick.sv
// Rotate-priority encoder: first asserted req searching upward from last+1,
// wrapping modulo NUM_CHAINS.
module umtrx_rr_pick
  import umtrx_rx_arb_pkg::*;
#(
  parameter int NUM_CHAINS = 2
) (
  input  logic [NUM_CHAINS-1:0] req,
  input  logic [1:0]            last,
  output logic [1:0]            pick,
  output logic                  any
);

  logic [MAX_CHAINS-1:0] req_pad;
  logic [1:0]            idx;

  generate
    for (genvar gi = 0; gi < MAX_CHAINS; gi++) begin : g_pad
      if (gi < NUM_CHAINS) begin : g_live
        assign req_pad[gi] = req[gi];
      end else begin : g_dead
        assign req_pad[gi] = 1'b0;
      end
    end
  endgenerate

  // Walk from the farthest offset down so the nearest requester wins last.
  always_comb begin
    pick = '0;
    any  = 1'b0;
    idx  = '0;
    for (int k = NUM_CHAINS; k >= 1; k--) begin
      idx = 2'((int'(last) + k) % NUM_CHAINS);
      if (req_pad[idx]) begin
        pick = idx;
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/umtrx_rx_arbiter.sv
// Packet-granular round-robin merge of RX chain VITA streams onto one path.
// Optional per-chain packet counters when UMTRX_RX_ARB_STATS_EN is defined.
module umtrx_rx_arbiter
  import umtrx_rx_arb_pkg::*;
#(
  parameter int                    NUM_CHAINS   = 2,
  parameter int                    BASE         = 0,
  parameter logic [NUM_CHAINS-1:0] DEFAULT_MASK = '1
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst,
  input  logic                         set_stb,
  input  logic [7:0]                   set_addr,
  input  logic [31:0]                  set_data,
  input  logic [VITA_W*NUM_CHAINS-1:0] in_data,
  input  logic [NUM_CHAINS-1:0]        in_valid,
  output logic [NUM_CHAINS-1:0]        in_ready,
  output logic [VITA_W-1:0]            out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [1:0]                   cur_chain,
  output logic                         busy
`ifdef UMTRX_RX_ARB_STATS_EN
  ,
  input  logic [1:0]                   rb_sel,
  output logic [31:0]                  rb_data
`endif
);

  arb_state_t            state_reg, state_next;
  logic [1:0]            sel_reg, sel_next;
  logic [1:0]            last_reg, last_next;
  logic [NUM_CHAINS-1:0] mask_reg;
  logic [NUM_CHAINS-1:0] eligible;
  logic [1:0]            pick_idx;
  logic                  pick_any;
  logic                  mask_wr;
  logic                  eof_xfer;
  logic                  unused_set;

  logic [VITA_W-1:0]     chain_data [MAX_CHAINS];
  logic [MAX_CHAINS-1:0] valid_pad;

  // Padding to MAX_CHAINS lets a 2-bit select index every table directly.
  generate
    for (genvar gi = 0; gi < MAX_CHAINS; gi++) begin : g_chain
      if (gi < NUM_CHAINS) begin : g_live
        assign chain_data[gi] = in_data[gi*VITA_W +: VITA_W];
        assign valid_pad[gi]  = in_valid[gi];
      end else begin : g_dead
        assign chain_data[gi] = '0;
        assign valid_pad[gi]  = 1'b0;
      end
    end
  endgenerate

  assign eligible   = in_valid & mask_reg;
  assign mask_wr    = set_stb && (set_addr == 8'(BASE));
  assign unused_set = ^set_data;
  assign eof_xfer   = (state_reg == PASS) && valid_pad[sel_reg] && out_ready
                      && chain_data[sel_reg][EOF_BIT];

  umtrx_rr_pick #(
    .NUM_CHAINS(NUM_CHAINS)
  ) u_pick (
    .req  (eligible),
    .last (last_reg),
    .pick (pick_idx),
    .any  (pick_any)
  );

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    last_next  = last_reg;
    out_valid  = 1'b0;
    out_data   = '0;
    in_ready   = '0;
    case (state_reg)
      IDLE: begin
        if (pick_any) begin
          sel_next   = pick_idx;
          state_next = PASS;
        end
      end
      PASS: begin
        out_data  = chain_data[sel_reg];
        out_valid = valid_pad[sel_reg];
        for (int i = 0; i < NUM_CHAINS; i++) begin
          if (sel_reg == 2'(i)) in_ready[i] = out_ready;
        end
        if (eof_xfer) begin
          last_next  = sel_reg;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg <= IDLE;
      sel_reg   <= '0;
      last_reg  <= 2'(NUM_CHAINS - 1);
      mask_reg  <= DEFAULT_MASK;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      last_reg  <= last_next;
      if (mask_wr) mask_reg <= set_data[NUM_CHAINS-1:0];
    end
  end

  assign cur_chain = sel_reg;
  assign busy      = (state_reg == PASS);

`ifdef UMTRX_RX_ARB_STATS_EN
  logic        clr_wr;
  logic [31:0] pkt_cnt_reg [MAX_CHAINS];
  logic [31:0] rb_data_reg;

  assign clr_wr = set_stb && (set_addr == 8'(BASE + 1));

  always_ff @(posedge sys_clk) begin
    if (sys_rst || clr_wr) begin
      for (int k = 0; k < MAX_CHAINS; k++) pkt_cnt_reg[k] <= '0;
    end else begin
      for (int k = 0; k < MAX_CHAINS; k++) begin
        if (k < NUM_CHAINS && eof_xfer && sel_reg == 2'(k))
          pkt_cnt_reg[k] <= pkt_cnt_reg[k] + 32'd1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) rb_data_reg <= '0;
    else         rb_data_reg <= pkt_cnt_reg[rb_sel];
  end

  assign rb_data = rb_data_reg;
`endif

endmodule

// File: tb/tb_umtrx_rx_arbiter.sv
// Directed bench for umtrx_rx_arbiter: cycle table plus packet-source sequences.
module tb_umtrx_rx_arbiter;
  import umtrx_rx_arb_pkg::*;

  localparam int NC = 3;
  localparam int BASE_ADDR = 16;
  localparam logic [35:0] SOF = 36'h1_0000_0000;
  localparam logic [35:0] EOF = 36'h2_0000_0000;
  localparam logic [35:0] D11 = SOF | EOF | 36'h11;
  localparam logic [35:0] D12 = SOF | EOF | 36'h12;
  localparam logic [35:0] D02 = SOF | EOF | 36'h02;
  localparam logic [35:0] DA0 = SOF | 36'hA0;
  localparam logic [35:0] DA1 = EOF | 36'hA1;
  localparam logic [35:0] C1B2 = 36'h0_1000_0002;  // chain 1, pkt 0, beat 2

  logic           sys_clk = 1'b0;
  logic           sys_rst, set_stb, out_valid, out_ready, busy;
  logic [7:0]     set_addr;
  logic [31:0]    set_data;
  logic [NC*36-1:0] in_data;
  logic [NC-1:0]  in_valid, in_ready;
  logic [35:0]    out_data;
  logic [1:0]     cur_chain;
`ifdef UMTRX_RX_ARB_STATS_EN
  logic [1:0]     rb_sel;
  logic [31:0]    rb_data;
`endif

  always #5 sys_clk = ~sys_clk;

  umtrx_rx_arbiter #(.NUM_CHAINS(NC), .BASE(BASE_ADDR)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .set_stb(set_stb), .set_addr(set_addr),
    .set_data(set_data), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .cur_chain(cur_chain), .busy(busy)
`ifdef UMTRX_RX_ARB_STATS_EN
    , .rb_sel(rb_sel), .rb_data(rb_data)
`endif
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drive-side state
  bit          use_src;
  logic [NC-1:0] vld_v;
  logic [35:0] dat_v [NC];
  logic        rdy_v, rst_v, wr_v;
  logic [7:0]  wa_v;
  logic [31:0] wd_v;
  logic [1:0]  rbs_v;

  // Packet sources: beat counters advance on observed handshakes
  int src_en [NC], src_len [NC], src_max [NC], beat [NC], pkt [NC];
  logic [NC-1:0] hs_last;

  // Samples and transfer log
  logic        smp_ov, smp_busy;
  logic [35:0] smp_od;
  logic [NC-1:0] smp_ir;
  logic [1:0]  smp_cur;
  logic [31:0] smp_rb;
  int xf_chain [256], xf_pkt [256], xf_beat [256], xf_cyc [256];
  bit xf_sof [256], xf_eof [256];
  int xf_n = 0;
  int cyc = 0;

  function automatic logic [35:0] src_word(int i);
    logic [35:0] w;
    w = '0;
    w[31:28] = 4'(i);
    w[27:16] = 12'(pkt[i]);
    w[15:0]  = 16'(beat[i]);
    w[32]    = (beat[i] == 0);
    w[33]    = (beat[i] == src_len[i] - 1);
    return w;
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    for (int i = 0; i < NC; i++) begin
      if (hs_last[i]) begin
        beat[i]++;
        if (beat[i] == src_len[i]) begin
          beat[i] = 0;
          pkt[i]++;
        end
      end
    end
    #1;
    sys_rst = rst_v; set_stb = wr_v; set_addr = wa_v; set_data = wd_v; out_ready = rdy_v;
`ifdef UMTRX_RX_ARB_STATS_EN
    rb_sel = rbs_v;
`endif
    for (int i = 0; i < NC; i++) begin
      if (use_src) begin
        in_valid[i] = (src_en[i] != 0) && (src_max[i] == 0 || pkt[i] < src_max[i]);
        in_data[i*36 +: 36] = src_word(i);
      end else begin
        in_valid[i] = vld_v[i];
        in_data[i*36 +: 36] = dat_v[i];
      end
    end
    @(negedge sys_clk);
    smp_ov = out_valid; smp_od = out_data; smp_ir = in_ready;
    smp_busy = busy; smp_cur = cur_chain;
`ifdef UMTRX_RX_ARB_STATS_EN
    smp_rb = rb_data;
`else
    smp_rb = '0;
`endif
    hs_last = in_valid & in_ready;
    if (out_valid && out_ready && xf_n < 256) begin
      xf_chain[xf_n] = int'(out_data[31:28]);
      xf_pkt[xf_n]   = int'(out_data[27:16]);
      xf_beat[xf_n]  = int'(out_data[15:0]);
      xf_sof[xf_n]   = out_data[32];
      xf_eof[xf_n]   = out_data[33];
      xf_cyc[xf_n]   = cyc;
      $display("xfer cyc=%0d chain=%0d pkt=%0d beat=%0d sof=%0d eof=%0d", cyc,
               xf_chain[xf_n], xf_pkt[xf_n], xf_beat[xf_n], xf_sof[xf_n], xf_eof[xf_n]);
      xf_n++;
    end
    cyc++;
  endtask

  task automatic src_reset();
    for (int i = 0; i < NC; i++) begin
      src_en[i] = 0; src_len[i] = 4; src_max[i] = 0; beat[i] = 0; pkt[i] = 0;
    end
    hs_last = '0;
  endtask

  task automatic do_reset();
    rst_v = 1'b1; tick(); tick(); rst_v = 1'b0;
  endtask

  task automatic wr(logic [7:0] a, logic [31:0] d);
    wr_v = 1'b1; wa_v = a; wd_v = d; tick(); wr_v = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  vld;
    logic        rdy;
    logic [35:0] d0, d1, d2;
    logic        ov;
    logic [35:0] od;
    logic [2:0]  ir;
    logic        bsy;
    logic [1:0]  cur;
  } vec_t;

  vec_t tbl [12];

  initial begin
    bit ok;
    int idx, c1, eofi, after;

    tbl[0]  = '{3'b000, 1'b1, 36'h0, 36'h0, 36'h0, 1'b0, 36'h0, 3'b000, 1'b0, 2'd0};
    tbl[1]  = '{3'b010, 1'b1, 36'h0, D11,   36'h0, 1'b0, 36'h0, 3'b000, 1'b0, 2'd0};
    tbl[2]  = '{3'b010, 1'b1, 36'h0, D11,   36'h0, 1'b1, D11,   3'b010, 1'b1, 2'd1};
    tbl[3]  = '{3'b011, 1'b1, DA0,   D12,   36'h0, 1'b0, 36'h0, 3'b000, 1'b0, 2'd1};
    tbl[4]  = '{3'b011, 1'b0, DA0,   D12,   36'h0, 1'b1, DA0,   3'b000, 1'b1, 2'd0};
    tbl[5]  = '{3'b011, 1'b1, DA0,   D12,   36'h0, 1'b1, DA0,   3'b001, 1'b1, 2'd0};
    tbl[6]  = '{3'b011, 1'b1, DA1,   D12,   36'h0, 1'b1, DA1,   3'b001, 1'b1, 2'd0};
    tbl[7]  = '{3'b011, 1'b1, 36'h0, D12,   36'h0, 1'b0, 36'h0, 3'b000, 1'b0, 2'd0};
    tbl[8]  = '{3'b001, 1'b1, 36'h0, D12,   36'h0, 1'b0, D12,   3'b010, 1'b1, 2'd1};
    tbl[9]  = '{3'b011, 1'b1, 36'h0, D12,   36'h0, 1'b1, D12,   3'b010, 1'b1, 2'd1};
    tbl[10] = '{3'b100, 1'b1, 36'h0, 36'h0, D02,   1'b0, 36'h0, 3'b000, 1'b0, 2'd1};
    tbl[11] = '{3'b100, 1'b1, 36'h0, 36'h0, D02,   1'b1, D02,   3'b100, 1'b1, 2'd2};

    use_src = 0; vld_v = 3'b111; rdy_v = 1'b1; wr_v = 1'b0; wa_v = '0; wd_v = '0; rbs_v = '0;
    for (int i = 0; i < NC; i++) dat_v[i] = SOF | EOF;
    src_reset();

    // Reset state, with all inputs valid
    do_reset();
    check("rst_ov", smp_ov, 0);
    check("rst_od", smp_od, 0);
    check("rst_ir", smp_ir, 0);
    check("rst_busy", smp_busy, 0);
    check("rst_cur", smp_cur, 0);

    // Cycle table
    for (int k = 0; k < 12; k++) begin
      vld_v = tbl[k].vld; rdy_v = tbl[k].rdy;
      dat_v[0] = tbl[k].d0; dat_v[1] = tbl[k].d1; dat_v[2] = tbl[k].d2;
      tick();
      check($sformatf("tbl%0d_ov", k), smp_ov, tbl[k].ov);
      check($sformatf("tbl%0d_od", k), smp_od, tbl[k].od);
      check($sformatf("tbl%0d_ir", k), smp_ir, tbl[k].ir);
      check($sformatf("tbl%0d_busy", k), smp_busy, tbl[k].bsy);
      check($sformatf("tbl%0d_cur", k), smp_cur, tbl[k].cur);
    end

    // Mask = 0 stalls everything; reset beats a simultaneous mask write
    vld_v = '0; rdy_v = 1'b1;
    do_reset();
    wr(8'(BASE_ADDR), 32'h0);
    vld_v = 3'b111;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("mask0_idle%0d", k), {smp_busy, smp_ov, smp_ir}, 0);
    end
    rst_v = 1'b1; wr_v = 1'b1; wa_v = 8'(BASE_ADDR); wd_v = 32'h0;
    tick();
    rst_v = 1'b0; wr_v = 1'b0;
    tick(); tick();
    check("rst_wins_busy", smp_busy, 1);
    check("rst_wins_cur", smp_cur, 0);

    // Alternation: chains 0,1 continuous 4-beat packets, chain 2 masked off
    vld_v = '0;
    src_reset(); use_src = 1;
    do_reset();
    wr(8'(BASE_ADDR), 32'h3);
    src_en[0] = 1; src_en[1] = 1; src_en[2] = 1;
    xf_n = 0;
    for (int k = 0; k < 44; k++) tick();
    check("alt_count", xf_n >= 16, 1);
    for (int p = 0; p < 4; p++) begin
      ok = 1;
      for (int b = 0; b < 4; b++) begin
        idx = p*4 + b;
        if (xf_chain[idx] != p % 2 || xf_beat[idx] != b || xf_pkt[idx] != p / 2) ok = 0;
      end
      check($sformatf("alt_pkt%0d", p), ok, 1);
      if (p > 0) check($sformatf("alt_gap%0d", p), xf_cyc[p*4] - xf_cyc[p*4-1], 2);
    end

    // Stall: chain 1 only, out_ready dropped mid-packet
    src_reset();
    do_reset();
    src_en[1] = 1; src_max[1] = 1;
    xf_n = 0;
    for (int k = 0; k < 20 && xf_n < 2; k++) tick();
    rdy_v = 1'b0;
    tick();
    check("stall_ov", smp_ov, 1);
    check("stall_od0", smp_od, C1B2);
    check("stall_ir", smp_ir, 0);
    tick();
    check("stall_od1", smp_od, C1B2);
    rdy_v = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    check("stall_count", xf_n, 4);
    ok = 1;
    for (int b = 0; b < 4; b++) if (xf_beat[b] != b || xf_chain[b] != 1) ok = 0;
    check("stall_order", ok, 1);

    // Mask write during a chain-1 packet
    src_reset();
    do_reset();
    src_en[0] = 1; src_en[1] = 1;
    xf_n = 0;
    for (int k = 0; k < 30 && !(xf_n > 0 && xf_chain[xf_n-1] == 1); k++) tick();
    wr(8'(BASE_ADDR), 32'h1);
    for (int k = 0; k < 30; k++) tick();
    c1 = 0; eofi = -1; after = 0; ok = 1;
    for (int j = 0; j < xf_n; j++) begin
      if (eofi >= 0) begin
        after++;
        if (xf_chain[j] != 0) ok = 0;
      end else if (xf_chain[j] == 1) begin
        if (xf_beat[j] != c1) ok = 0;
        c1++;
        if (xf_eof[j]) eofi = j;
      end
    end
    check("maskwr_c1_beats", c1, 4);
    check("maskwr_only_c0", ok, 1);
    check("maskwr_c0_after", after >= 4, 1);

    // Single-beat packets on three chains
    src_reset();
    do_reset();
    for (int i = 0; i < NC; i++) begin src_en[i] = 1; src_len[i] = 1; end
    xf_n = 0;
    for (int k = 0; k < 14; k++) tick();
    check("sb_count", xf_n >= 6, 1);
    ok = 1;
    for (int j = 0; j < 6; j++) if (xf_chain[j] != j % 3) ok = 0;
    check("sb_order", ok, 1);
    ok = 1;
    for (int j = 0; j < 6; j++) if (!xf_sof[j] || !xf_eof[j]) ok = 0;
    check("sb_sof_eof", ok, 1);
    ok = 1;
    for (int j = 1; j < 6; j++) if (xf_cyc[j] - xf_cyc[j-1] != 2) ok = 0;
    check("sb_spacing", ok, 1);

    // Reset on beat 2 of a chain-1 packet
    src_reset();
    do_reset();
    src_en[0] = 1; src_en[1] = 1;
    xf_n = 0;
    ok = 0;
    for (int k = 0; k < 40 && !ok; k++) begin
      tick();
      if (xf_n > 0 && xf_chain[xf_n-1] == 1 && xf_beat[xf_n-1] == 1) ok = 1;
    end
    check("mrst_found", ok, 1);
    rst_v = 1'b1;
    tick();
    check("mrst_beat2", smp_od, C1B2);
    rst_v = 1'b0;
    tick();
    check("mrst_ov", smp_ov, 0);
    check("mrst_od", smp_od, 0);
    check("mrst_ir", smp_ir, 0);
    check("mrst_busy_cur", {smp_busy, smp_cur}, 0);
    xf_n = 0;
    for (int k = 0; k < 10; k++) tick();
    check("mrst_first", (xf_n > 0) ? xf_chain[0] : -1, 0);

`ifdef UMTRX_RX_ARB_STATS_EN
    // Packet counters and clear
    src_reset();
    do_reset();
    src_en[0] = 1; src_max[0] = 5; src_len[0] = 2;
    src_en[1] = 1; src_max[1] = 3; src_len[1] = 2;
    for (int k = 0; k < 60; k++) tick();
    rbs_v = 2'd0; tick(); tick();
    check("stat_c0", smp_rb, 5);
    rbs_v = 2'd1; tick(); tick();
    check("stat_c1", smp_rb, 3);
    wr(8'(BASE_ADDR + 1), 32'h0);
    tick(); tick();
    check("stat_clr_c1", smp_rb, 0);
    rbs_v = 2'd0; tick(); tick();
    check("stat_clr_c0", smp_rb, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
